// File: rtl/alu_arbiter.sv
// Two-port front end for one shared combinational ALU: arbitrates, latches the
// winning request, runs it for one cycle and returns a tagged, held response.
module alu_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned OPW        = 5,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*XLEN-1:0] req_pc,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [OPW-1:0]    alu_op,
    output logic [XLEN-1:0]   alu_pc,
    input  logic [XLEN-1:0]   alu_c,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_c,
    output logic              rsp_zero,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [OPW-1:0] OP_NOP  = '0;
    localparam logic [OPW-1:0] OP_LAST = OPW'(17);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, pc_q, pc_d;
    logic [OPW-1:0]    op_q, op_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [XLEN-1:0]   rsp_c_q, rsp_c_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0]        grant;
    logic              sel;
    logic              illegal;
    logic              in_exec;

    always_comb begin
        grant = '0;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ((FIXED_PRIO != 0) || !rr_q) ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];
    assign illegal   = (op_q > OP_LAST);
    assign in_exec   = (state_q == EXEC);

    // ALU inputs are gated to zero/nop outside EXEC so the shared unit stays quiet.
    assign alu_a  = in_exec ? a_q  : '0;
    assign alu_b  = in_exec ? b_q  : '0;
    assign alu_pc = in_exec ? pc_q : '0;
    assign alu_op = (in_exec && !illegal) ? op_q : OP_NOP;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        pc_d        = pc_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d     = sel ? req_a[2*XLEN-1:XLEN]  : req_a[XLEN-1:0];
                    b_d     = sel ? req_b[2*XLEN-1:XLEN]  : req_b[XLEN-1:0];
                    pc_d    = sel ? req_pc[2*XLEN-1:XLEN] : req_pc[XLEN-1:0];
                    op_d    = sel ? req_op[2*OPW-1:OPW]   : req_op[OPW-1:0];
                    id_d    = sel;
                    rr_d    = ~sel;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_err_d   = illegal;
                rsp_c_d     = illegal ? '0   : alu_c;
                rsp_zero_d  = illegal ? 1'b1 : alu_zero;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            pc_q        <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port plus a transaction-level
// model of grant order, latency and response contents.
module tb_alu_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OPW        = 5;
    localparam int unsigned FIXED_PRIO = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [2*XLEN-1:0] req_a = '0, req_b = '0, req_pc = '0;
    logic [2*OPW-1:0]  req_op = '0;
    logic [XLEN-1:0]   alu_a, alu_b, alu_pc, alu_c;
    logic [OPW-1:0]    alu_op;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [XLEN-1:0]   rsp_c;
    logic              rsp_zero, rsp_err;

    int checks = 0;
    int errors = 0;
    int rr_ptr = 0;

    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [31:0] rpc[2];
    logic [4:0]  rop[2];

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_pc(req_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_pc(alu_pc),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // nop and undefined opcodes return a nonzero pattern so result squashing is visible.
    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, b, pc);
        case (op)
            5'd1:    return b;
            5'd2:    return pc + b;
            5'd3:    return a + b;
            5'd4:    return a - b;
            5'd5:    return 32'(a != b);
            5'd6:    return 32'($signed(a) < $signed(b));
            5'd7:    return 32'($signed(a) >= $signed(b));
            5'd8:    return 32'(a < b);
            5'd9:    return 32'(a >= b);
            5'd10:   return 32'($signed(a) < $signed(b));
            5'd11:   return 32'(a < b);
            5'd12:   return a ^ b;
            5'd13:   return a | b;
            5'd14:   return a & b;
            5'd15:   return a << b[4:0];
            5'd16:   return a >> b[4:0];
            5'd17:   return 32'($signed(a) >>> b[4:0]);
            default: return a ^ 32'h5A5A_5A5A ^ {27'd0, op};
        endcase
    endfunction

    always_comb begin
        alu_c    = alu_f(alu_op, alu_a, alu_b, alu_pc);
        alu_zero = (alu_c == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_rsp_c"},     rsp_c,          32'd0);
        chk({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
        chk({tag, "_alu_a"},     alu_a,          32'd0);
        chk({tag, "_alu_b"},     alu_b,          32'd0);
        chk({tag, "_alu_pc"},    alu_pc,         32'd0);
    endtask

    task automatic drive(input logic [1:0] v);
        req_valid = v;
        req_a     = {ra[1], ra[0]};
        req_b     = {rb[1], rb[0]};
        req_pc    = {rpc[1], rpc[0]};
        req_op    = {rop[1], rop[0]};
    endtask

    // One complete transaction; called #1 after a rising edge with the DUT idle.
    task automatic run_one(input logic [1:0] v, input int unsigned hold);
        int          w;
        logic        legal;
        logic [31:0] ec;
        logic        ez, ee;
        drive(v);
        rsp_ready = 1'b0;
        w = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : ((FIXED_PRIO != 0) ? 0 : rr_ptr);
        legal = (rop[w] <= 5'd17);
        ec = legal ? alu_f(rop[w], ra[w], rb[w], rpc[w]) : 32'd0;
        ez = legal ? (ec == 32'd0) : 1'b1;
        ee = !legal;
        #1;
        chk("ready_idle", 32'(req_ready), (w == 0) ? 32'd1 : 32'd2);
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        tick();
        rr_ptr = 1 - w;
        chk("ready_exec", 32'(req_ready), 32'd0);
        chk("alu_op_exec", 32'(alu_op), legal ? 32'(rop[w]) : 32'd0);
        chk("alu_a_exec", alu_a, ra[w]);
        chk("alu_b_exec", alu_b, rb[w]);
        chk("alu_pc_exec", alu_pc, rpc[w]);
        chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
        tick();
        for (int unsigned k = 0; k <= hold; k++) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(w));
            chk("rsp_c", rsp_c, ec);
            chk("rsp_zero", 32'(rsp_zero), 32'(ez));
            chk("rsp_err", 32'(rsp_err), 32'(ee));
            chk("ready_resp", 32'(req_ready), 32'd0);
            chk("alu_op_resp", 32'(alu_op), 32'd0);
            chk("alu_a_resp", alu_a, 32'd0);
            rsp_ready = (k == hold);
            tick();
        end
        chk("rsp_valid_retired", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; rb[i] = '0; rpc[i] = '0; rop[i] = '0;
        end
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();

        // single add on port 0
        ra[0] = 32'd5; rb[0] = 32'd7; rop[0] = 5'd3;
        chk("add_expect_model", alu_f(5'd3, 32'd5, 32'd7, 32'd0), 32'd12);
        run_one(2'b01, 0);

        // zero flag via sub, then auipc, both on port 1
        ra[1] = 32'd3; rb[1] = 32'd3; rop[1] = 5'd4;
        run_one(2'b10, 0);
        rpc[1] = 32'h1000; rb[1] = 32'h20; rop[1] = 5'd2;
        run_one(2'b10, 0);

        // contention
        ra[0] = 32'd1;  rb[0] = 32'd1;  rop[0] = 5'd3;
        ra[1] = 32'hF0; rb[1] = 32'h0F; rop[1] = 5'd12;
        run_one(2'b11, 0);
        run_one(2'b10, 0);
        run_one(2'b11, 0);
        run_one(2'b11, 0);

        // backpressure on an arithmetic shift
        ra[0] = 32'h8000_0000; rb[0] = 32'd4; rop[0] = 5'd17;
        run_one(2'b01, 4);

        // illegal opcode on port 1
        ra[1] = 32'h1234; rb[1] = 32'h5678; rop[1] = 5'b10011;
        run_one(2'b10, 0);

        // no valid: nothing is accepted
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // reset while in EXEC
        ra[0] = 32'd9; rb[0] = 32'd1; rop[0] = 5'd3;
        drive(2'b01);
        tick();
        chk("rstexec_alu_op", 32'(alu_op), 32'd3);
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("rstexec");
        rr_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstexec_no_rsp", 32'(rsp_valid), 32'd0);
        end
        ra[1] = 32'd2; rb[1] = 32'd2; rop[1] = 5'd14;
        run_one(2'b11, 0);

        // reset while in RESP
        drive(2'b10);
        tick();
        req_valid = '0;
        tick();
        chk("rstresp_valid_before", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("rstresp");
        rr_ptr = 0;
        tick();
        chk("rstresp_no_rsp", 32'(rsp_valid), 32'd0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                ra[i]  = $urandom;
                rb[i]  = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
                rpc[i] = $urandom;
                rop[i] = 5'($urandom_range(0, 19));
            end
            run_one(2'($urandom_range(1, 3)), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the integer pipe and a multi-cycle address/branch helper.
- Each request is accepted through a valid/ready handshake and arbitrated round-robin, or with fixed priority when configured.
- The block drives the ALU from registered operands and captures the result.
- It returns the result on a single response channel tagged with the requester id.

Parameters:
- XLEN, 32, operand/result width.
- OPW, 5, ALU opcode width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port accept; combinational
- req_a  in  2*XLEN  operand A; port i at [XLEN*i +: XLEN]
- req_b  in  2*XLEN  operand B, packed the same way
- req_op  in  2*OPW  opcode; port i at [OPW*i +: OPW]
- req_pc  in  2*XLEN  PC for auipc, packed the same way
- alu_a  out  XLEN  to ALU A
- alu_b  out  XLEN  to ALU B
- alu_op  out  OPW  to ALU ALUOp
- alu_pc  out  XLEN  to ALU PC
- alu_c  in  XLEN  ALU result
- alu_zero  in  1  ALU Zero
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester the response belongs to
- rsp_c  out  XLEN  result
- rsp_zero  out  1  result == 0
- rsp_err  out  1  opcode was not a legal ALU op

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_c=0, rsp_zero=0, rsp_err=0, alu_op=nop (5'b00000), alu_a=alu_b=alu_pc=0, RR pointer=0.
- Grant, computed only in IDLE:
  - Exactly one valid: that port is granted.
  - Both valid, FIXED_PRIO=1: port 0.
  - Both valid, FIXED_PRIO=0: the port selected by the RR pointer.
- Handshake: req_ready[i] = (state==IDLE) & grant[i]. At most one ready bit is high. Both ready bits are 0 in EXEC and RESP.
- Acceptance: occurs when req_valid[i] & req_ready[i]. On that edge:
  - latch a/b/op/pc of port i and id=i;
  - state -> EXEC;
  - the RR pointer moves to the other port (pointer = ~i).
  - The pointer is updated on every grant, regardless of contention.
- EXEC (exactly one cycle):
  - alu_* outputs are driven from the latched registers.
  - At the end of the cycle: rsp_c <= alu_c, rsp_zero <= alu_zero, rsp_id <= latched id; state -> RESP.
- Illegal op (latched op > 5'b10001):
  - alu_op is driven as nop.
  - rsp_c=0, rsp_zero=1, rsp_err=1.
  - Legal ops give rsp_err=0.
- RESP:
  - rsp_valid=1, and rsp_id/c/zero/err are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid <= 0, state -> IDLE, alu_op -> nop, alu_a/b/pc -> 0.
- Outside EXEC, alu_op=nop and alu_a/b/pc=0, so the shared ALU sees no spurious activity.
- Latency: accept in cycle 0, EXEC in cycle 1, rsp_valid from cycle 2. With rsp_ready held high, the next accept is in cycle 3 (one op per 3 cycles).
- Requesters are not required to hold valid when not granted. The block never reorders requests and never buffers more than one.
- Reset mid-operation (EXEC or RESP): the in-flight request is dropped with no response. All outputs return to reset values on the next edge.
- req_valid deasserted before ready: no acceptance, no state change.
- Opcode map:
  - nop=0, lui=1, auipc=2, add=3, sub=4, bne=5, blt=6, bge=7, bltu=8, bgeu=9
  - slt=10, sltu=11, xor=12, or=13, and=14, sll=15, srl=16, sra=17

Test Plan:
- Single add: port0 a=5, b=7, op=3 in cycle 0 -> req_ready=2'b01 in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_c=12, rsp_zero=0, rsp_err=0.
- Zero flag and auipc:
  - port1 sub a=3, b=3 -> rsp_c=0, rsp_zero=1, rsp_id=1.
  - port1 auipc pc=0x1000, b=0x20 -> rsp_c=0x1020.
- Contention: both ports valid from reset, port0 add 1+1, port1 xor 0xF0^0x0F, rsp_ready=1:
  - port0 is granted first (rsp_c=2, id=0);
  - port1 is accepted in cycle 3 (rsp_c=0xFF, id=1);
  - both valid again -> port0 wins (pointer has returned to 0).
- Backpressure: port0 sra a=0x80000000, b=4, rsp_ready=0 for 4 cycles -> rsp_valid stays 1 and rsp_c stays 0xF8000000; req_ready=2'b00 throughout; the response retires on the first rsp_ready=1 edge.
- Illegal op 5'b10011 on port1 -> alu_op observed as 0 during EXEC; rsp_c=0, rsp_zero=1, rsp_err=1.
- Reset in EXEC: accept a port0 add, assert rst in cycle 1 -> no rsp_valid ever appears; all outputs at reset values; a fresh request afterwards is served by port0 (pointer reset to 0).
